// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encodings.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout set on underflow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result and borrow registered.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done,
    output state_t           state
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               br_q;
    logic [IDX_W-1:0]   idx_q;
    logic               bit_d;
    logic               bit_bout;

    full_subtractor u_fs (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are captured once so later input changes cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            br_q  <= 1'b0;
            idx_q <= '0;
            Diff  <= '0;
            Bout  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        br_q  <= Bin;
                        idx_q <= '0;
                    end
                end
                ST_RUN: begin
                    Diff[idx_q] <= bit_d;
                    br_q        <= bit_bout;
                    if (idx_q == LAST_IDX) begin
                        Bout  <= bit_bout;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: vector table, exhaustive sweep and multi-cycle corner sequences.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         busy;
    logic         done;
    state_t       dut_state;

    logic [W:0]   exp_q[$];
    int           done_cyc_q[$];
    int           checks;
    int           failures;
    int           done_cnt;
    int           cyc;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done),
        .state (dut_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: every done pulse consumes one expected {Bout, Diff}
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done: got {Bout,Diff}=%h expected no done", {Bout, Diff});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({Bout, Diff} !== e) begin
                    failures++;
                    $display("FAIL sb_result: got {Bout,Diff}=%h expected %h", {Bout, Diff}, e);
                end
            end
        end
    end

    // driver tasks (all leave the caller 1ns after a rising edge)
    task automatic wait_idle();
        for (int k = 0; k < 2 * W + 8; k++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        wait_idle();
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b, bin));
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    vec_t vecs[8];
    int   lat;
    int   base;

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;

        vecs[0] = '{a: 4'h9, b: 4'h3, bin: 1'b0, diff: 4'h6, bout: 1'b0};
        vecs[1] = '{a: 4'h3, b: 4'h9, bin: 1'b0, diff: 4'hA, bout: 1'b1};
        vecs[2] = '{a: 4'h0, b: 4'h0, bin: 1'b1, diff: 4'hF, bout: 1'b1};
        vecs[3] = '{a: 4'hF, b: 4'hF, bin: 1'b0, diff: 4'h0, bout: 1'b0};
        vecs[4] = '{a: 4'h0, b: 4'h1, bin: 1'b0, diff: 4'hF, bout: 1'b1};
        vecs[5] = '{a: 4'h8, b: 4'h0, bin: 1'b1, diff: 4'h7, bout: 1'b0};
        vecs[6] = '{a: 4'hF, b: 4'h0, bin: 1'b1, diff: 4'hE, bout: 1'b0};
        vecs[7] = '{a: 4'h5, b: 4'h5, bin: 1'b1, diff: 4'hF, bout: 1'b1};

        // start held during reset must not be accepted
        start = 1'b1; A = 4'h7; B = 4'h1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("reset_state", int'(dut_state), int'(ST_IDLE));
        check("reset_diff", int'(Diff), 0);
        check("reset_bout", int'(Bout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // vector table
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            if (i == 0) begin
                check("run_busy", int'(busy), 1);
                check("run_done_low", int'(done), 0);
            end
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_diff", i), int'(Diff), int'(vecs[i].diff));
            check($sformatf("vec%0d_bout", i), int'(Bout), int'(vecs[i].bout));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            check($sformatf("vec%0d_idle_after", i), int'(busy), 0);
            check($sformatf("vec%0d_diff_hold", i), int'(Diff), int'(vecs[i].diff));
        end

        // reset two cycles into RUN aborts without a done pulse
        wait_idle();
        base = done_cnt;
        A = 4'hF; B = 4'h0; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", int'(dut_state), int'(ST_IDLE));
        check("abort_diff", int'(Diff), 0);
        check("abort_bout", int'(Bout), 0);
        check("abort_busy", int'(busy), 0);
        repeat (W + 3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - base, 0);

        // start re-pulsed during RUN is ignored
        base = done_cnt;
        start_op(4'h9, 4'h3, 1'b0);
        @(posedge clk); #1;
        A = 4'h1; B = 4'h1; Bin = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("repulse_diff", int'(Diff), 6);
        check("repulse_bout", int'(Bout), 0);
        repeat (W + 3) @(posedge clk);
        #1;
        check("repulse_one_op", done_cnt - base, 1);
        check("repulse_idle", int'(busy), 0);

        // operands toggled after capture do not affect the result
        for (int t = 0; t < 6; t++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            logic [W:0]   e;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            e = model(ra, rb, rbin);
            start_op(ra, rb, rbin);
            lat = -1;
            for (int k = 1; k <= W + 4; k++) begin
                A = W'($urandom_range(0, 15));
                B = W'($urandom_range(0, 15));
                Bin = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (done) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("toggle%0d_latency", t), lat, W);
            check($sformatf("toggle%0d_result", t), int'({Bout, Diff}), int'(e));
        end

        // back-to-back: start held high gives one operation per W+2 cycles
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        base = done_cnt;
        done_cyc_q.delete();
        A = 4'hC; B = 4'h5; Bin = 1'b1; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(4'hC, 4'h5, 1'b1));
        repeat (2) begin
            repeat (W + 2) @(posedge clk);
            exp_q.push_back(model(4'hC, 4'h5, 1'b1));
        end
        #1;
        start = 1'b0;
        wait_idle();
        repeat (W + 3) @(posedge clk);
        #1;
        check("b2b_ops", done_cnt - base, 3);
        if (done_cyc_q.size() == 3) begin
            check("b2b_period1", done_cyc_q[1] - done_cyc_q[0], W + 2);
            check("b2b_period2", done_cyc_q[2] - done_cyc_q[1], W + 2);
        end else begin
            check("b2b_done_count", done_cyc_q.size(), 3);
        end

        // exhaustive sweep, checked through the scoreboard
        base = done_cnt;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    start_op(W'(a), W'(b), 1'(c));
                    wait_done(lat);
                    check("sweep_latency", lat, W);
                end
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("sweep_done_count", done_cnt - base, 512);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
